// File: rtl/csa_accum_seq_if.sv
// ============================================================================
// Module   : csa_accum_seq_if
// Brief    : Job control, operand stream and result stream for csa_accum_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface csa_accum_seq_if #(
  parameter int WIDTH = 49,
  parameter int CNT_W = 4
);

  logic             Start_SI;
  logic [CNT_W-1:0] NumOps_DI;
  logic             Abort_SI;
  logic [WIDTH-1:0] Op_DI;
  logic             OpValid_SI;
  logic             OpReady_SO;
  logic [WIDTH-1:0] Result_DO;
  logic             ResValid_SO;
  logic             ResReady_SI;
  logic             Busy_SO;

  // Sequencer side: issues jobs, streams operands, consumes results
  modport master (
    output Start_SI, NumOps_DI, Abort_SI, Op_DI, OpValid_SI, ResReady_SI,
    input  OpReady_SO, Result_DO, ResValid_SO, Busy_SO
  );

  modport slave (
    input  Start_SI, NumOps_DI, Abort_SI, Op_DI, OpValid_SI, ResReady_SI,
    output OpReady_SO, Result_DO, ResValid_SO, Busy_SO
  );

endinterface

`default_nettype wire

// File: rtl/csa_accum_seq.sv
// ============================================================================
// Module   : csa_accum_seq
// Brief    : Multi-operand adder keeping a carry-save running total,
//            resolved by a single carry-propagate add at the end of a job.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csa_accum_seq #(
  parameter int WIDTH = 49,
  parameter int CNT_W = 4
) (
  input  wire logic         Clk_CI,
  input  wire logic         Rst_RBI,
  csa_accum_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] carry_sh;
  logic             op_hs;

  // Carry vector is weighted one bit up; its MSB falls off (mod 2^WIDTH)
  assign carry_sh = {carry_q[WIDTH-2:0], 1'b0};
  assign op_hs    = bus.OpValid_SI && (state_q == ACCUM);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    if (bus.Abort_SI) begin
      // Abort outranks everything, including a same-cycle operand handshake
      state_d  = IDLE;
      sum_d    = '0;
      carry_d  = '0;
      result_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Start_SI) begin
            sum_d   = '0;
            carry_d = '0;
            cnt_d   = bus.NumOps_DI;
            state_d = (bus.NumOps_DI != '0) ? ACCUM : RESOLVE;
          end
        end
        ACCUM: begin
          if (op_hs) begin
            sum_d   = sum_q ^ carry_sh ^ bus.Op_DI;
            carry_d = (sum_q & carry_sh) | (sum_q & bus.Op_DI) | (carry_sh & bus.Op_DI);
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = RESOLVE;
            end
          end
        end
        RESOLVE: begin
          result_d = sum_q + carry_sh;
          state_d  = DONE;
        end
        DONE: begin
          if (bus.ResReady_SI) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.OpReady_SO  = (state_q == ACCUM);
  assign bus.ResValid_SO = (state_q == DONE);
  assign bus.Busy_SO     = (state_q != IDLE);
  assign bus.Result_DO   = result_q;

endmodule

`default_nettype wire
